// File: rtl/class_mem_pkg.sv
// Shared types, default geometry and helpers for the banked class-hypervector store.
package class_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FTWIDTH_D       = 8;
  localparam int M_SIZE_D        = 16;
  localparam int DIM_D           = 4000;
  localparam int NUM_CLASS_MAX_D = 26;

  function automatic int depth_f(input int n, input int dim, input int m);
    return (n * dim + m - 1) / m;
  endfunction

  // Even parity bit over up to 64 data bits (unused upper bits are zero).
  function automatic logic even_par_f(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/class_mem_banked_if.sv
// Load/read bus of the banked class store; master = client, slave = store.
interface class_mem_banked_if
  import class_mem_pkg::*;
#(
  parameter int FTWIDTH       = FTWIDTH_D,
  parameter int M_SIZE        = M_SIZE_D,
  parameter int DIM           = DIM_D,
  parameter int NUM_CLASS_MAX = NUM_CLASS_MAX_D
) ();
  localparam int DEPTH      = depth_f(NUM_CLASS_MAX, DIM, M_SIZE);
  localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                             load_start;
  logic [4:0]                       class_num;
  logic                             wr_valid;
  logic                             wr_ready;
  logic [FTWIDTH-1:0]               class_in;
  logic                             rd_en;
  logic [ADDR_WIDTH-1:0]            read_address;
  logic                             rd_valid;
  logic [M_SIZE-1:0][FTWIDTH-1:0]   class_out;
  logic                             write_done;
  logic                             cfg_err;
  logic                             par_err;

  modport master (
    output load_start, class_num, wr_valid, class_in, rd_en, read_address,
    input  wr_ready, rd_valid, class_out, write_done, cfg_err, par_err
  );

  modport slave (
    input  load_start, class_num, wr_valid, class_in, rd_en, read_address,
    output wr_ready, rd_valid, class_out, write_done, cfg_err, par_err
  );
endinterface

// File: rtl/class_mem_bank.sv
// One bank: single-port RAM with registered read port; contents are never reset.
module class_mem_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] dout_r;

  // RAM write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

  // Read register holds its value between reads
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_r <= '0;
    end else if (re) begin
      dout_r <= mem[addr];
    end
  end

  assign dout = dout_r;
endmodule

// File: rtl/class_mem_banked.sv
// Banked class store: load FSM stripes elements round-robin over M_SIZE banks, then serves word reads.
// Optional CLASS_MEM_PARITY_EN adds one even-parity bit per stored element and a sticky par_err.
module class_mem_banked
  import class_mem_pkg::*;
#(
  parameter int FTWIDTH       = FTWIDTH_D,
  parameter int M_SIZE        = M_SIZE_D,
  parameter int DIM           = DIM_D,
  parameter int NUM_CLASS_MAX = NUM_CLASS_MAX_D
) (
  input logic               clk,
  input logic               reset,
  class_mem_banked_if.slave bus
);
  localparam int DEPTH      = depth_f(NUM_CLASS_MAX, DIM, M_SIZE);
  localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W      = $clog2(NUM_CLASS_MAX * DIM + 1);
  localparam int PTR_W      = (M_SIZE > 1) ? $clog2(M_SIZE) : 1;
`ifdef CLASS_MEM_PARITY_EN
  localparam int BANK_W     = FTWIDTH + 1;
`else
  localparam int BANK_W     = FTWIDTH;
`endif

  state_t                  state_r, next_s;
  logic [CNT_W-1:0]        total_r, count_r;
  logic [PTR_W-1:0]        ptr_r;
  logic [ADDR_WIDTH-1:0]   wr_addr_r;
  logic                    wr_ready_r, write_done_r, cfg_err_r, rd_valid_r, oor_r;
  logic                    legal_s, start_s, beat_s, last_s, rd_fire_s, oor_s;
  logic [ADDR_WIDTH-1:0]   rd_addr_s, bank_addr_s;
  logic [BANK_W-1:0]       din_s;
  logic [BANK_W-1:0]       dout_s [M_SIZE];
  logic [M_SIZE-1:0][FTWIDTH-1:0] class_out_s;

  assign legal_s   = (bus.class_num != 5'd0) && (32'(bus.class_num) <= 32'(NUM_CLASS_MAX));
  assign start_s   = bus.load_start && (state_r != LOAD);
  assign beat_s    = bus.wr_valid && wr_ready_r;
  assign last_s    = beat_s && (count_r == total_r - CNT_W'(1));
  assign rd_fire_s = bus.rd_en && (state_r == DONE);
  assign oor_s     = 32'(bus.read_address) >= 32'(DEPTH);
  assign rd_addr_s = oor_s ? '0 : bus.read_address;
  assign bank_addr_s = (state_r == LOAD) ? wr_addr_r : rd_addr_s;

  // Next-state logic of the load FSM
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.load_start && legal_s) next_s = LOAD;
        else                           next_s = IDLE;
      end
      LOAD: begin
        if (last_s) next_s = DONE;
        else        next_s = LOAD;
      end
      DONE: begin
        if (bus.load_start && legal_s) next_s = LOAD;
        else                           next_s = DONE;
      end
      default: next_s = IDLE;
    endcase
  end

  // State, striping counters, status flags and read pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      total_r      <= '0;
      count_r      <= '0;
      ptr_r        <= '0;
      wr_addr_r    <= '0;
      wr_ready_r   <= 1'b0;
      write_done_r <= 1'b0;
      cfg_err_r    <= 1'b0;
      rd_valid_r   <= 1'b0;
      oor_r        <= 1'b0;
    end else begin
      state_r      <= next_s;
      wr_ready_r   <= (next_s == LOAD);
      write_done_r <= (next_s == DONE);
      rd_valid_r   <= rd_fire_s;
      if (rd_fire_s) begin
        oor_r <= oor_s;
      end
      if (start_s && legal_s) begin
        total_r   <= CNT_W'(bus.class_num) * CNT_W'(DIM);
        count_r   <= '0;
        ptr_r     <= '0;
        wr_addr_r <= '0;
      end else if (beat_s) begin
        count_r <= count_r + CNT_W'(1);
        if (ptr_r == PTR_W'(M_SIZE - 1)) begin
          ptr_r     <= '0;
          wr_addr_r <= wr_addr_r + ADDR_WIDTH'(1);
        end else begin
          ptr_r <= ptr_r + PTR_W'(1);
        end
      end
      if (start_s && !legal_s) begin
        cfg_err_r <= 1'b1;
      end
    end
  end

`ifdef CLASS_MEM_PARITY_EN
  logic par_bad_s, par_err_r;
  assign din_s = {even_par_f(64'(bus.class_in)), bus.class_in};

  // Any bank whose stored word has odd parity flags corruption
  always_comb begin
    par_bad_s = 1'b0;
    for (int k = 0; k < M_SIZE; k++) begin
      par_bad_s = par_bad_s | (^dout_s[k]);
    end
  end

  // Sticky parity error, sampled on every in-range read
  always_ff @(posedge clk) begin
    if (reset) begin
      par_err_r <= 1'b0;
    end else if (rd_valid_r && !oor_r && par_bad_s) begin
      par_err_r <= 1'b1;
    end
  end
  assign bus.par_err = par_err_r;
`else
  assign din_s       = bus.class_in;
  assign bus.par_err = 1'b0;
`endif

  for (genvar k = 0; k < M_SIZE; k++) begin : g_bank
    class_mem_bank #(.WIDTH(BANK_W), .DEPTH(DEPTH), .AW(ADDR_WIDTH)) u_bank (
      .clk   (clk),
      .reset (reset),
      .we    (beat_s && (ptr_r == PTR_W'(k))),
      .re    (rd_fire_s),
      .addr  (bank_addr_s),
      .din   (din_s),
      .dout  (dout_s[k])
    );
  end

  // Out-of-range reads return an all-zero word
  always_comb begin
    class_out_s = '0;
    for (int k = 0; k < M_SIZE; k++) begin
      if (oor_r) class_out_s[k] = '0;
      else       class_out_s[k] = dout_s[k][FTWIDTH-1:0];
    end
  end

  assign bus.wr_ready   = wr_ready_r;
  assign bus.write_done = write_done_r;
  assign bus.cfg_err    = cfg_err_r;
  assign bus.rd_valid   = rd_valid_r;
  assign bus.class_out  = class_out_s;
endmodule

// File: tb/tb_class_mem_banked.sv
// Scoreboard bench for class_mem_banked (M_SIZE=4, DIM=8, NUM_CLASS_MAX=3 -> DEPTH=6).
module tb_class_mem_banked;
  localparam int FW = 8, M = 4, D = 8, NC = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  class_mem_banked_if #(.FTWIDTH(FW), .M_SIZE(M), .DIM(D), .NUM_CLASS_MAX(NC)) bus ();
  class_mem_banked #(.FTWIDTH(FW), .M_SIZE(M), .DIM(D), .NUM_CLASS_MAX(NC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] word;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   beats;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every rd_valid must match the oldest expected read, on its due cycle
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got class_out=%h want no rd_valid", bus.class_out);
      end else begin
        e = exp_q.pop_front();
        if (bus.class_out !== e.word || cyc != e.due) begin
          errors++;
          $display("FAIL rd_word got %h at cycle %0d want %h at cycle %0d",
                   bus.class_out, cyc, e.word, e.due);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic start(input logic [4:0] n);
    bus.class_num  = n;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic feed(input int cycles, input bit toggle, input bit a5, output int nb);
    nb = 0;
    for (int c = 0; c < cycles; c++) begin
      bus.wr_valid = toggle ? (c % 2 == 0) : 1'b1;
      bus.class_in = a5 ? 8'hA5 : 8'(nb);
      if (bus.wr_valid && bus.wr_ready) nb++;
      tick();
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] w);
    bus.rd_en        = 1'b1;
    bus.read_address = a;
    exp_q.push_back('{word: w, due: cyc + 1});
    tick();
  endtask

  task automatic rd_stop();
    bus.rd_en = 1'b0;
    tick();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    bus.load_start   = 1'b0;
    bus.class_num    = 5'd0;
    bus.wr_valid     = 1'b0;
    bus.class_in     = 8'd0;
    bus.rd_en        = 1'b0;
    bus.read_address = 3'd0;
    tick();
    tick();
    chk("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_class_out", 64'(bus.class_out), 64'd0);
    chk("rst_write_done", 64'(bus.write_done), 64'd0);
    chk("rst_cfg_err", 64'(bus.cfg_err), 64'd0);
    chk("rst_par_err", 64'(bus.par_err), 64'd0);
    reset = 1'b0;
    tick();

    // 1: two classes, continuous stream 0..15
    start(5'd2);
    chk("t1_wr_ready", 64'(bus.wr_ready), 64'd1);
    feed(20, 1'b0, 1'b0, beats);
    chk("t1_beats", 64'(beats), 64'd16);
    chk("t1_wr_ready_low", 64'(bus.wr_ready), 64'd0);
    chk("t1_write_done", 64'(bus.write_done), 64'd1);
    rd(3'd0, 32'h03020100);
    rd(3'd1, 32'h07060504);
    rd(3'd2, 32'h0B0A0908);
    rd(3'd3, 32'h0F0E0D0C);
    rd_stop();

    // 2: reload one class from DONE with gapped wr_valid
    start(5'd1);
    chk("t2_write_done_drop", 64'(bus.write_done), 64'd0);
    chk("t2_wr_ready", 64'(bus.wr_ready), 64'd1);
    feed(20, 1'b1, 1'b0, beats);
    chk("t2_beats", 64'(beats), 64'd8);
    chk("t2_write_done", 64'(bus.write_done), 64'd1);
    rd(3'd1, 32'h07060504);
    rd(3'd2, 32'h0B0A0908);
    rd_stop();

    // 3: illegal class counts
    pulse_reset();
    start(5'd0);
    chk("t3_cfg_err_0", 64'(bus.cfg_err), 64'd1);
    chk("t3_wr_ready_0", 64'(bus.wr_ready), 64'd0);
    pulse_reset();
    chk("t3_cfg_err_clr", 64'(bus.cfg_err), 64'd0);
    start(5'd4);
    chk("t3_cfg_err_4", 64'(bus.cfg_err), 64'd1);
    tick();
    chk("t3_wr_ready_4", 64'(bus.wr_ready), 64'd0);
    chk("t3_write_done_4", 64'(bus.write_done), 64'd0);

    // 4: reset mid-load, then full three-class load of 0xA5
    start(5'd2);
    feed(5, 1'b0, 1'b1, beats);
    chk("t4_partial_beats", 64'(beats), 64'd5);
    pulse_reset();
    chk("t4_rst_write_done", 64'(bus.write_done), 64'd0);
    chk("t4_rst_wr_ready", 64'(bus.wr_ready), 64'd0);
    start(5'd3);
    feed(30, 1'b0, 1'b1, beats);
    chk("t4_beats", 64'(beats), 64'd24);
    chk("t4_write_done", 64'(bus.write_done), 64'd1);
    rd(3'd6, 32'h00000000);
    rd(3'd7, 32'h00000000);
    for (int a = 0; a < 6; a++) rd(3'(a), 32'hA5A5A5A5);
    rd_stop();

    // 5: reads ignored during LOAD, then back-to-back reads
    start(5'd1);
    bus.rd_en        = 1'b1;
    bus.read_address = 3'd0;
    tick();
    chk("t5_rd_valid_load", 64'(bus.rd_valid), 64'd0);
    chk("t5_class_out_hold", 64'(bus.class_out), 64'hA5A5A5A5);
    tick();
    chk("t5_rd_valid_load2", 64'(bus.rd_valid), 64'd0);
    bus.rd_en = 1'b0;
    feed(12, 1'b0, 1'b0, beats);
    chk("t5_beats", 64'(beats), 64'd8);
    rd(3'd0, 32'h03020100);
    rd(3'd1, 32'h07060504);
    rd(3'd2, 32'hA5A5A5A5);
    rd_stop();
    tick();

`ifdef CLASS_MEM_PARITY_EN
    // 6: corrupt one stored bit and observe the sticky flag
    chk("t6_par_clean", 64'(bus.par_err), 64'd0);
    dut.g_bank[2].u_bank.mem[0][0] = ~dut.g_bank[2].u_bank.mem[0][0];
    rd(3'd0, 32'h03030100);
    rd_stop();
    tick();
    chk("t6_par_set", 64'(bus.par_err), 64'd1);
    rd(3'd1, 32'h07060504);
    rd_stop();
    tick();
    chk("t6_par_sticky", 64'(bus.par_err), 64'd1);
`else
    chk("t6_par_tied", 64'(bus.par_err), 64'd0);
`endif

    tick();
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
